// File: rtl/iir_onepole_mc.sv
// Multi-channel one-pole IIR (LPF/HPF) with a single shared multiplier.
// One channel is processed per cycle; results are published together in DONE.
module iir_onepole_mc #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int COEF_W = 8
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] datain,
  input  logic [COEF_W-1:0]        coef,
  input  logic                     hpf_mode,
  input  logic                     clear_state,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] dataout
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW1  = DATA_W + 1;
  localparam int PW   = DATA_W + COEF_W + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q;
  logic signed [DATA_W-1:0]  x_q   [NUM_CH];
  logic signed [DATA_W-1:0]  y_q   [NUM_CH];
  logic signed [DATA_W-1:0]  res_q [NUM_CH];
  logic [COEF_W-1:0]         coef_q;
  logic                      mode_q;

  logic                      accept;
  logic                      last_ch;
  logic signed [DATA_W-1:0]  x_cur, y_cur, y_new, hp_sat, out_cur;
  logic signed [DW1-1:0]     d, hp;
  logic signed [PW-1:0]      d_ext, c_ext, y_ext, p, p_sh;
  logic [NUM_CH*DATA_W-1:0]  dataout_d;

  assign accept  = in_valid && in_ready;
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (last_ch) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared datapath: y_new = y + floor((x - y) * coef / 2^COEF_W)
  always_comb begin
    x_cur = x_q[ch_q];
    y_cur = y_q[ch_q];
    d     = {x_cur[DATA_W-1], x_cur} - {y_cur[DATA_W-1], y_cur};
    d_ext = {{(PW-DW1){d[DW1-1]}}, d};
    c_ext = {{(PW-COEF_W){1'b0}}, coef_q};
    y_ext = {{(PW-DATA_W){y_cur[DATA_W-1]}}, y_cur};
    p     = d_ext * c_ext;
    p_sh  = p >>> COEF_W;
    y_new = DATA_W'(y_ext + p_sh);
    hp    = {x_cur[DATA_W-1], x_cur} - {y_new[DATA_W-1], y_new};
    if (hp[DW1-1] != hp[DW1-2])
      hp_sat = hp[DW1-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      hp_sat = hp[DATA_W-1:0];
    out_cur = mode_q ? hp_sat : y_new;
  end

  // Earlier channels come from res_q; the channel in flight is merged in directly.
  always_comb begin
    dataout_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == ch_q)
        dataout_d[(NUM_CH-1-i)*DATA_W +: DATA_W] = out_cur;
      else
        dataout_d[(NUM_CH-1-i)*DATA_W +: DATA_W] = res_q[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      coef_q  <= '0;
      mode_q  <= 1'b0;
      dataout <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (clear_state) begin
            for (int unsigned i = 0; i < NUM_CH; i++) y_q[i] <= '0;
          end
          if (accept) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
              x_q[i] <= datain[(NUM_CH-1-i)*DATA_W +: DATA_W];
            coef_q <= coef;
            mode_q <= hpf_mode;
            ch_q   <= '0;
          end
        end
        CALC: begin
          y_q[ch_q]   <= y_new;
          res_q[ch_q] <= out_cur;
          if (last_ch) dataout <= dataout_d;
          else         ch_q    <= ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_onepole_mc.sv
// Scoreboard bench for iir_onepole_mc: a behavioural model predicts each frame at accept time.
module tb_iir_onepole_mc;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 2;
  localparam int COEF_W = 8;
  localparam int FW     = NUM_CH * DATA_W;

  logic              Clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     datain = '0;
  logic [COEF_W-1:0] coef = '0;
  logic              hpf_mode = 1'b0;
  logic              clear_state = 1'b0;
  logic              out_valid;
  logic [FW-1:0]     dataout;

  iir_onepole_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .COEF_W(COEF_W)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .coef(coef), .hpf_mode(hpf_mode), .clear_state(clear_state),
    .out_valid(out_valid), .dataout(dataout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [FW-1:0] data;
    int            acc;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_out = 0;
  int            m_y [NUM_CH];
  exp_t          q [$];
  logic [FW-1:0] last_out = '0;

  always @(posedge Clk) cyc++;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint floor_div(input longint p, input longint den);
    if (p >= 0) return p / den;
    return -((-p + den - 1) / den);
  endfunction

  // Monitor/model: inputs change at posedge+1, so the negedge sees settled values.
  always @(negedge Clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < NUM_CH; i++) m_y[i] = 0;
      last_out = '0;
    end else begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out_valid cyc=%0d dataout=%h expected no output", cyc, dataout);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (dataout !== e.data) begin
            errors++;
            $display("FAIL frame_data cyc=%0d got %h expected %h", cyc, dataout, e.data);
          end
          checks++;
          if (cyc - e.acc != NUM_CH + 1) begin
            errors++;
            $display("FAIL latency got %0d expected %0d", cyc - e.acc, NUM_CH + 1);
          end
        end
        last_out = dataout;
        n_out++;
      end else begin
        checks++;
        if (dataout !== last_out) begin
          errors++;
          $display("FAIL dataout_hold cyc=%0d got %h expected %h", cyc, dataout, last_out);
        end
      end
      if (in_ready && clear_state)
        for (int i = 0; i < NUM_CH; i++) m_y[i] = 0;
      if (in_ready && in_valid) begin
        exp_t e;
        e.acc = cyc;
        e.data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          logic signed [DATA_W-1:0] xs;
          int x, yn, o;
          longint pr;
          xs = datain[(NUM_CH-1-i)*DATA_W +: DATA_W];
          x  = xs;
          pr = longint'(x - m_y[i]) * longint'(int'(coef));
          yn = m_y[i] + int'(floor_div(pr, longint'(1) << COEF_W));
          o  = hpf_mode ? sat(x - yn) : yn;
          e.data[(NUM_CH-1-i)*DATA_W +: DATA_W] = o[DATA_W-1:0];
          m_y[i] = yn;
        end
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] x1,
                      input int c, input bit hpf, input bit clr);
    bit ok;
    ok = 0;
    @(posedge Clk); #1;
    datain = {x0, x1}; coef = COEF_W'(c); hpf_mode = hpf; clear_state = clr; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge Clk); #1;
    in_valid = 1'b0; clear_state = 1'b0;
    coef = ~coef; hpf_mode = ~hpf_mode;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic wait_out();
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL output_timeout pending=%0d expected 0", q.size());
    end
  endtask

  task automatic check_ch(input string name, input int ch, input int exp_v);
    logic signed [DATA_W-1:0] v;
    v = last_out[(NUM_CH-1-ch)*DATA_W +: DATA_W];
    checks++;
    if (int'(v) != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, v, exp_v);
    end
  endtask

  task automatic pulse_clear();
    @(posedge Clk); #1; clear_state = 1'b1;
    @(posedge Clk); #1; clear_state = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dataout !== '0) begin
        errors++;
        $display("FAIL reset_idle in_ready=%b out_valid=%b dataout=%h expected 1 0 0",
                 in_ready, out_valid, dataout);
      end
    end
  endtask

  task automatic test_lpf_step();
    int exp0 [3] = '{500, 750, 875};
    for (int f = 0; f < 3; f++) begin
      send(16'd1000, 16'd0, 128, 1'b0, 1'b0);
      clear_state = 1'b1;            // ignored while busy
      @(posedge Clk); #1 clear_state = 1'b0;
      wait_out();
      check_ch("lpf_step_ch0", 0, exp0[f]);
    end
  endtask

  task automatic test_coef_zero();
    pulse_clear();
    send(16'd1234, 16'hF000, 0, 1'b0, 1'b0);
    wait_out();
    check_ch("coef0_ch0", 0, 0);
    check_ch("coef0_ch1", 1, 0);
    send(16'd1000, 16'd0, 128, 1'b0, 1'b0);
    wait_out();
    send(16'd7000, 16'd0, 0, 1'b0, 1'b0);
    wait_out();
    check_ch("coef0_hold", 0, 500);
    send(16'd1000, 16'd0, 128, 1'b0, 1'b1);
    wait_out();
    check_ch("clear_with_accept", 0, 500);
  endtask

  task automatic test_hpf_sat();
    int exp1 [3] = '{32639, 32766, 32766};
    pulse_clear();
    for (int f = 0; f < 3; f++) begin
      send(16'd0, 16'd32767, 255, 1'b0, 1'b0);
      wait_out();
      check_ch("lpf255_ch1", 1, exp1[f]);
    end
    send(16'd0, 16'h8000, 0, 1'b1, 1'b0);
    wait_out();
    check_ch("hpf_sat_ch1", 1, -32768);
    check_ch("hpf_zero_ch0", 0, 0);
  endtask

  task automatic test_back_to_back();
    int prev, accepts, start_out;
    prev = -1; accepts = 0; start_out = n_out;
    @(posedge Clk); #1;
    datain = FW'({$urandom, $urandom}); coef = COEF_W'($urandom_range(0, 255));
    hpf_mode = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    for (int k = 0; k < 100 && accepts < 6; k++) begin
      @(negedge Clk);
      if (in_ready) begin
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != NUM_CH + 2) begin
            errors++;
            $display("FAIL accept_spacing got %0d expected %0d", cyc - prev, NUM_CH + 2);
          end
        end
        prev = cyc;
        accepts++;
        @(posedge Clk); #1;
        datain = FW'({$urandom, $urandom}); coef = COEF_W'($urandom_range(0, 255));
        hpf_mode = 1'($urandom_range(0, 1));
        if (accepts == 6) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_out();
    checks++;
    if (n_out - start_out != 6 || accepts != 6) begin
      errors++;
      $display("FAIL b2b_count outputs=%0d accepts=%0d expected 6 6", n_out - start_out, accepts);
    end
  endtask

  task automatic test_reset_mid_calc();
    send(16'd300, 16'd400, 200, 1'b0, 1'b0);
    @(posedge Clk); #1 reset = 1'b1;
    @(posedge Clk); #1 reset = 1'b0;
    repeat (6) @(negedge Clk);
    checks++;
    if (dataout !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_calc dataout=%h in_ready=%b expected 0 1", dataout, in_ready);
    end
    send(16'd1000, 16'd2000, 128, 1'b0, 1'b0);
    wait_out();
    check_ch("post_reset_ch0", 0, 500);
    check_ch("post_reset_ch1", 1, 1000);
  endtask

  initial begin
    test_reset();
    test_lpf_step();
    test_coef_zero();
    test_hpf_sat();
    test_back_to_back();
    test_reset_mid_calc();
    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end
endmodule
